// File: rtl/plot_pkg.sv
// Shared constants, state encoding and position helpers
// for the VGA pixel-port scheduler.
package plot_pkg;

  localparam int unsigned SCR_W = 160;
  localparam int unsigned SCR_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_TIMER = 3'b111;
  localparam logic [2:0] COL_P0    = 3'b001;
  localparam logic [2:0] COL_P1    = 3'b010;
  localparam logic [2:0] COL_P2    = 3'b100;
  localparam logic [2:0] COL_P3    = 3'b110;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_WINNER = 2'd2
  } state_e;

  function automatic logic [2:0] player_colour(
    input logic [1:0] idx
  );
    logic [2:0] c;
    unique case (idx)
      2'd0:    c = COL_P0;
      2'd1:    c = COL_P1;
      2'd2:    c = COL_P2;
      default: c = COL_P3;
    endcase
    return c;
  endfunction

  // Positions are packed {x[7:0], y[6:0]}.
  function automatic logic [7:0] pos_x(
    input logic [14:0] pos
  );
    return pos[14:7];
  endfunction

  function automatic logic [6:0] pos_y(
    input logic [14:0] pos
  );
    return pos[6:0];
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter, combinational.
// Ports: req_i/mask_i requests and exclusions, ptr_i
// highest-priority index; gnt_o one-hot, idx_o winner,
// ptr_o pointer after this grant, valid_o any winner.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [3:0] mask_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic [1:0] ptr_o,
  output logic       valid_o
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the
  // nearest eligible requester overwrites the rest.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand] && !mask_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    gnt_o = valid_o ? (4'b0001 << idx_o) : 4'b0000;
    ptr_o = idx_o + 2'd1;
  end

endmodule

// File: rtl/plot_scheduler.sv
// Arbitrates the single VGA pixel-write port between
// players, timer bar, a full-screen clear and the winner.
// Ports: CLOCK_50/reset (sync, active-high); p_req/p_pos,
// p_gnt players; t_req/t_x, t_gnt timer; clear_start,
// show_winner, winner controls; clear_busy/clear_done
// sweep status; x/y/colour/plot pixel write.
module plot_scheduler
  import plot_pkg::*;
#(
  parameter int X_MAX    = SCR_W - 1,
  parameter int Y_MAX    = SCR_H - 1,
  parameter int TIMER_Y  = SCR_H - 1,
  parameter int WINNER_X = 85,
  parameter int WINNER_Y = 42
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  p_req,
  input  logic [59:0] p_pos,
  output logic [3:0]  p_gnt,
  input  logic        t_req,
  input  logic [7:0]  t_x,
  output logic        t_gnt,
  input  logic        clear_start,
  input  logic        show_winner,
  input  logic [1:0]  winner,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot
);

  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);
  localparam logic [6:0] TY = 7'(TIMER_Y);
  localparam logic [7:0] WX = 8'(WINNER_X);
  localparam logic [6:0] WY = 7'(WINNER_Y);

  state_e     state_q, state_d;
  logic [1:0] rr_q, rr_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] col_q, col_d;
  logic       plot_q, plot_d;
  logic [3:0] pgnt_q, pgnt_d;
  logic       tgnt_q, tgnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;

  logic [3:0]  arb_gnt;
  logic [1:0]  arb_idx;
  logic [1:0]  arb_ptr;
  logic        arb_valid;
  logic [14:0] pos_a [4];
  logic [14:0] sel_pos;

  // Players granted last cycle still hold req this
  // cycle, so mask them to avoid a double grant.
  rr_arbiter4 u_arb (
    .req_i   (p_req),
    .mask_i  (pgnt_q),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .ptr_o   (arb_ptr),
    .valid_o (arb_valid)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pos_a[i] = p_pos[15*i +: 15];
    end
    sel_pos = pos_a[arb_idx];
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    pgnt_d  = 4'b0000;
    tgnt_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cx_d    = cx_q;
    cy_d    = cy_q;
    unique case (state_q)
      ST_ARB: begin
        if (clear_start) begin
          // Pixel (0,0) goes out now; counters
          // point at the next one.
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          x_d     = 8'd0;
          y_d     = 7'd0;
          col_d   = COL_BLACK;
          plot_d  = 1'b1;
          cx_d    = 8'd0;
          cy_d    = 7'd1;
        end else if (show_winner) begin
          state_d = ST_WINNER;
          x_d     = WX;
          y_d     = WY;
          col_d   = player_colour(winner);
          plot_d  = 1'b1;
        end else if (arb_valid) begin
          pgnt_d  = arb_gnt;
          rr_d    = arb_ptr;
          x_d     = pos_x(sel_pos);
          y_d     = pos_y(sel_pos);
          col_d   = player_colour(arb_idx);
          plot_d  = 1'b1;
        end else if (t_req && !tgnt_q) begin
          tgnt_d  = 1'b1;
          x_d     = t_x;
          y_d     = TY;
          col_d   = COL_TIMER;
          plot_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        // cx past the last column marks the
        // cycle after the final pixel.
        if (cx_q > XM) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cx_d    = 8'd0;
          cy_d    = 7'd0;
          state_d = show_winner ? ST_WINNER
                                : ST_ARB;
        end else begin
          x_d    = cx_q;
          y_d    = cy_q;
          col_d  = COL_BLACK;
          plot_d = 1'b1;
          if (cy_q == YM) begin
            cy_d = 7'd0;
            cx_d = cx_q + 8'd1;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end
      end
      ST_WINNER: begin
        x_d    = WX;
        y_d    = WY;
        col_d  = player_colour(winner);
        plot_d = 1'b1;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_ARB;
      rr_q    <= 2'd0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      col_q   <= COL_BLACK;
      plot_q  <= 1'b0;
      pgnt_q  <= 4'b0000;
      tgnt_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cx_q    <= 8'd0;
      cy_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      pgnt_q  <= pgnt_d;
      tgnt_q  <= tgnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  assign p_gnt      = pgnt_q;
  assign t_gnt      = tgnt_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = col_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler: directed
// scenarios plus randomized requesters vs a model.
module tb_plot_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [3:0]  p_req;
  logic [59:0] p_pos;
  logic [3:0]  p_gnt;
  logic        t_req;
  logic [7:0]  t_x;
  logic        t_gnt;
  logic        clear_start;
  logic        show_winner;
  logic [1:0]  winner;
  logic        clear_busy;
  logic        clear_done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  plot_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .p_req       (p_req),
    .p_pos       (p_pos),
    .p_gnt       (p_gnt),
    .t_req       (t_req),
    .t_x         (t_x),
    .t_gnt       (t_gnt),
    .clear_start (clear_start),
    .show_winner (show_winner),
    .winner      (winner),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: mode 0 arbitrating, 1 sweeping, 2 winner.
  int         m_mode = 0;
  int         m_rr   = 0;
  int         m_k    = 0;
  logic [7:0] e_x    = '0;
  logic [6:0] e_y    = '0;
  logic [2:0] e_col  = '0;
  logic       e_plot = 1'b0;
  logic [3:0] e_pgnt = '0;
  logic       e_tgnt = 1'b0;
  logic       e_busy = 1'b0;
  logic       e_done = 1'b0;

  logic [2:0] PCOL [4] = '{3'b001, 3'b010, 3'b100, 3'b110};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] prev_g;
    logic       prev_t;
    int         pick;
    int         i;
    prev_g = e_pgnt;
    prev_t = e_tgnt;
    pick   = -1;
    e_plot = 1'b0;
    e_pgnt = '0;
    e_tgnt = 1'b0;
    e_done = 1'b0;
    if (reset) begin
      m_mode = 0; m_rr = 0; m_k = 0;
      e_x = '0; e_y = '0; e_col = '0;
      e_busy = 1'b0;
    end else if (m_mode == 0) begin
      if (clear_start) begin
        m_mode = 1; m_k = 1;
        e_x = '0; e_y = '0; e_col = '0;
        e_plot = 1'b1; e_busy = 1'b1;
      end else if (show_winner) begin
        m_mode = 2;
        e_x = 8'd85; e_y = 7'd42;
        e_col = PCOL[winner]; e_plot = 1'b1;
      end else begin
        for (int off = 0; off < 4; off++) begin
          i = (m_rr + off) % 4;
          if (pick < 0 && p_req[i] && !prev_g[i])
            pick = i;
        end
        if (pick >= 0) begin
          e_pgnt[pick] = 1'b1;
          m_rr  = (pick + 1) % 4;
          e_x   = p_pos[15*pick+7 +: 8];
          e_y   = p_pos[15*pick +: 7];
          e_col = PCOL[pick];
          e_plot = 1'b1;
        end else if (t_req && !prev_t) begin
          e_tgnt = 1'b1;
          e_x = t_x; e_y = 7'd119;
          e_col = 3'b111; e_plot = 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      if (m_k == 19200) begin
        e_done = 1'b1; e_busy = 1'b0;
        m_mode = show_winner ? 2 : 0;
      end else begin
        e_x = 8'(m_k / 120);
        e_y = 7'(m_k % 120);
        e_col = '0; e_plot = 1'b1;
        m_k++;
      end
    end else begin
      e_x = 8'd85; e_y = 7'd42;
      e_col = PCOL[winner]; e_plot = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge CLOCK_50);
    model_step();
  end

  initial forever begin
    @(negedge CLOCK_50);
    if (cmp_en)
      chk("cycle",
          32'({x, y, colour, plot, p_gnt, t_gnt,
               clear_busy, clear_done}),
          32'({e_x, e_y, e_col, e_plot, e_pgnt,
               e_tgnt, e_busy, e_done}));
  end

  task automatic step();
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [3:0] drop;
  logic       tdrop;

  initial begin
    reset = 1'b1; p_req = '0; p_pos = '0;
    t_req = 1'b0; t_x = '0; clear_start = 1'b0;
    show_winner = 1'b0; winner = '0;
    drop = '0; tdrop = 1'b0;
    repeat (2) step();
    cmp_en = 1'b1;
    chk("reset_out",
        32'({x, y, colour, plot, p_gnt, t_gnt,
             clear_busy, clear_done}), 32'd0);
    reset = 1'b0;

    // single player grant, then masked cycle
    p_pos[14:0] = {8'd10, 7'd20};
    p_req = 4'b0001;
    step();
    chk("t1_gnt", 32'(p_gnt), 32'd1);
    chk("t1_pix", 32'({x, y, colour, plot}),
        32'({8'd10, 7'd20, 3'b001, 1'b1}));
    step();
    chk("t1_masked", 32'({p_gnt, plot}), 32'd0);
    chk("t1_hold", 32'({x, y}),
        32'({8'd10, 7'd20}));
    p_req = 4'b0000;
    step();

    // round-robin with all players holding req
    do_reset();
    p_pos = 60'({$urandom(), $urandom()});
    p_req = 4'hf;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_rr", 32'(p_gnt), 32'(1 << (k % 4)));
    end
    p_req = 4'h0;
    step();

    // player first, timer after
    do_reset();
    p_req = 4'b0100; t_req = 1'b1; t_x = 8'd37;
    step();
    chk("t3_p2", 32'({p_gnt, t_gnt}), 32'b01000);
    step();
    chk("t3_tmr", 32'({p_gnt, t_gnt, x, y, colour, plot}),
        32'({4'b0000, 1'b1, 8'd37, 7'd119,
             3'b111, 1'b1}));
    p_req = '0; t_req = 1'b0;
    step();

    // clear sweep with a pending player
    clear_start = 1'b1;
    p_req = 4'b0010;
    p_pos[29:15] = {8'd77, 7'd66};
    step();
    chk("t4_first",
        32'({clear_busy, x, y, colour, plot, p_gnt}),
        32'({1'b1, 8'd0, 7'd0, 3'b000, 1'b1, 4'b0}));
    clear_start = 1'b0;
    repeat (19199) step();
    chk("t4_last",
        32'({x, y, plot, clear_busy, clear_done}),
        32'({8'd159, 7'd119, 1'b1, 1'b1, 1'b0}));
    step();
    chk("t4_done", 32'({clear_done, clear_busy, plot}),
        32'b100);
    step();
    chk("t4_pend", 32'({p_gnt, x, y, colour, plot}),
        32'({4'b0010, 8'd77, 7'd66, 3'b010, 1'b1}));
    p_req = '0;
    step();

    // reset in the middle of a sweep
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (4999) step();
    chk("t6_px", 32'({x, y, plot}),
        32'({8'd41, 7'd79, 1'b1}));
    reset = 1'b1;
    step();
    chk("t6_rst",
        32'({x, y, colour, plot, p_gnt, t_gnt,
             clear_busy, clear_done}), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_nodone", 32'({clear_done, clear_busy}),
          32'd0);
    end

    // winner requested during the sweep
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (100) step();
    show_winner = 1'b1; winner = 2'd2;
    repeat (19099) step();
    step();
    chk("t5_done", 32'(clear_done), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_win", 32'({x, y, colour, plot}),
          32'({8'd85, 7'd42, 3'b100, 1'b1}));
    end
    show_winner = 1'b0;
    do_reset();

    // randomized players and timer
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 4; i++) begin
        if (drop[i]) begin
          p_req[i] = 1'b0;
          drop[i]  = 1'b0;
        end else if (p_req[i] && p_gnt[i]) begin
          drop[i] = 1'b1;
        end else if (!p_req[i] &&
                     $urandom_range(0, 2) == 0) begin
          p_req[i] = 1'b1;
          p_pos[15*i +: 15] = 15'($urandom());
        end
      end
      if (tdrop) begin
        t_req = 1'b0;
        tdrop = 1'b0;
      end else if (t_req && t_gnt) begin
        tdrop = 1'b1;
      end else if (!t_req &&
                   $urandom_range(0, 1) == 0) begin
        t_req = 1'b1;
        t_x   = 8'($urandom_range(0, 159));
      end
    end
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
